// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit:
// FSM states, mux select codes, ALU operations and condition codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH,
      S_UNKNOWN
   } statetype;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing command field Funct[4:1]
   localparam logic [3:0] FN_ADD = 4'b0100;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_AND = 4'b0000;
   localparam logic [3:0] FN_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluation; the condition result is
// captured in DECODE and gates every architectural write of the instruction.
module cond_unit
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       latch_cond,
   output logic       condex_q
);

   logic [3:0] flags;
   logic       condex;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      condex = 1'b0;
      case (cond)
         COND_EQ: condex = z;
         COND_NE: condex = ~z;
         COND_CS: condex = c;
         COND_CC: condex = ~c;
         COND_MI: condex = n;
         COND_PL: condex = ~n;
         COND_VS: condex = v;
         COND_VC: condex = ~v;
         COND_HI: condex = c & ~z;
         COND_LS: condex = ~c | z;
         COND_GE: condex = (n == v);
         COND_LT: condex = (n != v);
         COND_GT: condex = ~z & (n == v);
         COND_LE: condex = z | (n != v);
         COND_AL: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   // flag_w is only ever nonzero in the execute states, so flags change
   // solely at the edge that ends execution of a passing instruction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags    <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         if (latch_cond)
            condex_q <= condex;
         if (flag_w[1] && condex_q)
            flags[3:2] <= alu_flags[3:2];
         if (flag_w[0] && condex_q)
            flags[1:0] <= alu_flags[1:0];
      end
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: main FSM, ALU decode and PC/write-enable gating
// for the ARM-subset datapath.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [1:0] RegSrc
);

   statetype   state, next_state;
   logic       next_pc, branch, reg_w, mem_w, alu_op, ir_write;
   logic       pcs, condex_q;
   logic [1:0] flag_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_FETCH;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      alu_op     = 1'b0;
      ir_write   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      case (state)
         S_FETCH: begin
            ir_write   = 1'b1;
            next_pc    = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            case (Op)
               OP_MEM:  next_state = S_MEMADR;
               OP_DP:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   next_state = S_BRANCH;
               default: next_state = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB    = SRCB_EXTIMM;
            next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc     = 1'b1;
            next_state = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_w     = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         S_EXECUTER: begin
            alu_op     = 1'b1;
            next_state = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcB    = SRCB_EXTIMM;
            alu_op     = 1'b1;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_EXTIMM;
            ResultSrc = RES_ALURESULT;
            branch    = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   // Unsupported commands fall back to ADD and never touch the flags
   always_comb begin
      ALUControl = ALU_ADD;
      flag_w     = 2'b00;
      if (alu_op) begin
         case (Funct[4:1])
            FN_ADD: begin
               ALUControl = ALU_ADD;
               flag_w     = {Funct[0], Funct[0]};
            end
            FN_SUB: begin
               ALUControl = ALU_SUB;
               flag_w     = {Funct[0], Funct[0]};
            end
            FN_AND: begin
               ALUControl = ALU_AND;
               flag_w     = {Funct[0], 1'b0};
            end
            FN_ORR: begin
               ALUControl = ALU_ORR;
               flag_w     = {Funct[0], 1'b0};
            end
            default: begin
               ALUControl = ALU_ADD;
               flag_w     = 2'b00;
            end
         endcase
      end
   end

   cond_unit u_cond (
      .clk        (clk),
      .reset_n    (reset_n),
      .cond       (Cond),
      .alu_flags  (ALUFlags),
      .flag_w     (flag_w),
      .latch_cond (state == S_DECODE),
      .condex_q   (condex_q)
   );

   // reset_n masks the enables so the FETCH state held in reset writes nothing
   assign pcs      = branch | (reg_w & (Rd == 4'd15));
   assign PCWrite  = reset_n & (next_pc | (pcs & condex_q));
   assign RegWrite = reset_n & reg_w & condex_q;
   assign MemWrite = reset_n & mem_w & condex_q;
   assign IRWrite  = reset_n & ir_write;
   assign ImmSrc   = Op;
   assign RegSrc   = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: an instruction-level model predicts
// every output cycle by cycle; literal spot checks pin the model.
module tb_mc_controller;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] aluc;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic       regw;
      logic [1:0] regsrc;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;

   int         total = 0;
   int         bad = 0;
   vec_t       exp_q[$];
   vec_t       cap_vec[8];
   int         cap_idx = 0;
   string      cur_name = "none";
   logic [3:0] m_flags = 4'b0000;

   mc_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegWrite   (RegWrite),
      .RegSrc     (RegSrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_of(input logic [3:0] cmd);
      case (cmd)
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic vec_t base_vec(input logic [1:0] op);
      vec_t b;
      b        = '0;
      b.imm    = op;
      b.regsrc = {op == 2'b01, op == 2'b10};
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   // Queue the cycle-by-cycle outputs one instruction must produce, then run it
   task automatic applyStimulus(input string name, input logic [3:0] cc, input logic [1:0] op,
                                input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
      vec_t v;
      logic ok;
      int   n;
      ok = cond_holds(cc, m_flags);
      Cond = cc; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
      cur_name = name;
      cap_idx  = 0;
      n = 0;
      v = base_vec(op); v.pcw = 1; v.irw = 1; v.res = 2'b10; v.srca = 1; v.srcb = 2'b10;
      exp_q.push_back(v); n++;
      v = base_vec(op); v.res = 2'b10; v.srca = 1; v.srcb = 2'b10;
      exp_q.push_back(v); n++;
      case (op)
         2'b00: begin
            v = base_vec(op); v.srcb = fn[5] ? 2'b01 : 2'b00; v.aluc = alu_of(fn[4:1]);
            exp_q.push_back(v); n++;
            v = base_vec(op); v.regw = ok; v.pcw = ok && (rd == 4'd15);
            exp_q.push_back(v); n++;
            if (ok && fn[0]) begin
               if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010) m_flags = af;
               else if (fn[4:1] == 4'b0000 || fn[4:1] == 4'b1100) m_flags[3:2] = af[3:2];
            end
         end
         2'b01: begin
            v = base_vec(op); v.srcb = 2'b01;
            exp_q.push_back(v); n++;
            if (fn[0]) begin
               v = base_vec(op); v.adr = 1;
               exp_q.push_back(v); n++;
               v = base_vec(op); v.res = 2'b01; v.regw = ok; v.pcw = ok && (rd == 4'd15);
               exp_q.push_back(v); n++;
            end else begin
               v = base_vec(op); v.adr = 1; v.memw = ok;
               exp_q.push_back(v); n++;
            end
         end
         2'b10: begin
            v = base_vec(op); v.srcb = 2'b01; v.res = 2'b10; v.pcw = ok;
            exp_q.push_back(v); n++;
         end
         default: ;
      endcase
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      vec_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.pcw = PCWrite; a.adr = AdrSrc; a.memw = MemWrite; a.irw = IRWrite;
         a.res = ResultSrc; a.aluc = ALUControl; a.srca = ALUSrcA; a.srcb = ALUSrcB;
         a.imm = ImmSrc; a.regw = RegWrite; a.regsrc = RegSrc;
         if (cap_idx < 8) cap_vec[cap_idx] = a;
         total++;
         if (a !== e) begin
            bad++;
            $display("[TB] FAIL %s cyc%0d got=%h want=%h", cur_name, cap_idx + 1, a, e);
         end
         cap_idx++;
      end
   end

   initial begin
      reset_n = 1'b0;
      Cond = 4'b1110; Op = 2'b00; Funct = 6'b101000; Rd = 4'd1; ALUFlags = 4'b0000;
      #12;
      checkOutput("reset pcw", {1'b0, PCWrite}, 2'b00);
      checkOutput("reset irw", {1'b0, IRWrite}, 2'b00);
      checkOutput("reset regw", {1'b0, RegWrite}, 2'b00);
      checkOutput("reset srcb", ALUSrcB, 2'b10);
      checkOutput("reset res", ResultSrc, 2'b10);
      @(posedge clk);
      #1 reset_n = 1'b1;

      applyStimulus("addi", 4'hE, 2'b00, 6'b101000, 4'd1, 4'b1111);
      checkOutput("addi irw c1", {1'b0, cap_vec[0].irw}, 2'b01);
      checkOutput("addi pcw c1", {1'b0, cap_vec[0].pcw}, 2'b01);
      checkOutput("addi aluc c3", cap_vec[2].aluc, 2'b00);
      checkOutput("addi regw c3", {1'b0, cap_vec[2].regw}, 2'b00);
      checkOutput("addi regw c4", {1'b0, cap_vec[3].regw}, 2'b01);

      applyStimulus("subs", 4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
      checkOutput("subs aluc c3", cap_vec[2].aluc, 2'b01);
      applyStimulus("add eq", 4'h0, 2'b00, 6'b001000, 4'd2, 4'b0000);
      checkOutput("add eq regw c4", {1'b0, cap_vec[3].regw}, 2'b01);
      applyStimulus("add ne", 4'h1, 2'b00, 6'b001000, 4'd2, 4'b0000);
      checkOutput("add ne regw c4", {1'b0, cap_vec[3].regw}, 2'b00);

      applyStimulus("ldr", 4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
      checkOutput("ldr adr c4", {1'b0, cap_vec[3].adr}, 2'b01);
      checkOutput("ldr res c5", cap_vec[4].res, 2'b01);
      checkOutput("ldr regw c5", {1'b0, cap_vec[4].regw}, 2'b01);
      applyStimulus("str", 4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
      checkOutput("str memw c4", {1'b0, cap_vec[3].memw}, 2'b01);

      applyStimulus("b al", 4'hE, 2'b10, 6'b101000, 4'd0, 4'b0000);
      checkOutput("b al pcw c3", {1'b0, cap_vec[2].pcw}, 2'b01);
      applyStimulus("b nv", 4'hF, 2'b10, 6'b101000, 4'd0, 4'b0000);
      checkOutput("b nv pcw c3", {1'b0, cap_vec[2].pcw}, 2'b00);

      applyStimulus("add r15", 4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);
      checkOutput("add r15 pcw c4", {1'b0, cap_vec[3].pcw}, 2'b01);
      checkOutput("add r15 regw c4", {1'b0, cap_vec[3].regw}, 2'b01);
      applyStimulus("undef", 4'hE, 2'b11, 6'b000000, 4'd1, 4'b0000);

      applyStimulus("orrs", 4'hE, 2'b00, 6'b011001, 4'd4, 4'b1010);
      applyStimulus("addi mi", 4'h4, 2'b00, 6'b101000, 4'd4, 4'b0000);
      applyStimulus("bad cmd s", 4'hE, 2'b00, 6'b001111, 4'd4, 4'b0100);
      applyStimulus("add pl", 4'h5, 2'b00, 6'b001000, 4'd4, 4'b0000);
      applyStimulus("ands", 4'hE, 2'b00, 6'b000001, 4'd5, 4'b0111);
      applyStimulus("add eq2", 4'h0, 2'b00, 6'b001000, 4'd5, 4'b0000);
      applyStimulus("adds", 4'hE, 2'b00, 6'b001001, 4'd5, 4'b0011);
      applyStimulus("add hi", 4'h8, 2'b00, 6'b001000, 4'd5, 4'b0000);
      applyStimulus("add ge", 4'hA, 2'b00, 6'b001000, 4'd5, 4'b0000);
      applyStimulus("subs eq fail", 4'h0, 2'b00, 6'b000101, 4'd5, 4'b0100);
      applyStimulus("add eq3", 4'h0, 2'b00, 6'b001000, 4'd5, 4'b0000);

      Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd6; ALUFlags = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("str memw pre-reset", {1'b0, MemWrite}, 2'b01);
      reset_n = 1'b0;
      m_flags = 4'b0000;
      #1;
      checkOutput("str memw in reset", {1'b0, MemWrite}, 2'b00);
      checkOutput("reset2 srcb", ALUSrcB, 2'b10);
      checkOutput("reset2 pcw", {1'b0, PCWrite}, 2'b00);
      @(posedge clk);
      #1 reset_n = 1'b1;

      applyStimulus("add cs post-reset", 4'h2, 2'b00, 6'b001000, 4'd7, 4'b0000);
      checkOutput("post-reset regw c4", {1'b0, cap_vec[3].regw}, 2'b00);
      applyStimulus("addi post-reset", 4'hE, 2'b00, 6'b101000, 4'd7, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
